// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared state encoding and default parameters for the FIR sample sequencer
package fir_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      MAC,
      DRAIN,
      DONE
   } state_e;

   localparam int DEF_NUM_TAPS    = 32;
   localparam int DEF_MAC_LAT     = 2;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sample_strobe_sync.sv
// rtl/sample_strobe_sync.sv - synchroniser and registered rising-edge detector for the codec strobe
module sample_strobe_sync
   import fir_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sample_strb_i,
   output logic strb_p_o
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   sync_d;

   // The pulse is registered, so it appears SYNC_STAGES+1 cycles after the strobe is first seen.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chain    <= '0;
         sync_d   <= 1'b0;
         strb_p_o <= 1'b0;
      end else begin
         chain    <= {chain[SYNC_STAGES-2:0], sample_strb_i};
         sync_d   <= chain[SYNC_STAGES-1];
         strb_p_o <= chain[SYNC_STAGES-1] & ~sync_d;
      end
   end

endmodule

// File: rtl/fir_sample_sequencer.sv
// rtl/fir_sample_sequencer.sv - per-sample write and symmetric MAC address sequencer for a folded FIR
module fir_sample_sequencer
   import fir_seq_pkg::*;
#(
   parameter int NUM_TAPS    = DEF_NUM_TAPS,
   parameter int ADDR_W      = $clog2(NUM_TAPS),
   parameter int MAC_LAT     = DEF_MAC_LAT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              sample_strb_i,
   input  logic              enable_i,
   input  logic              clr_overrun_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [ADDR_W-1:0] rd_a_addr_o,
   output logic [ADDR_W-1:0] rd_b_addr_o,
   output logic [ADDR_W-2:0] coef_addr_o,
   output logic              mac_clr_o,
   output logic              mac_en_o,
   output logic              out_valid_o,
   output logic              busy_o,
   output logic              overrun_o
);

   localparam int K_W = ADDR_W - 1;
   localparam int D_W = $clog2(MAC_LAT + 1);
   localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
   localparam logic [K_W-1:0]    K_ONE  = K_W'(1);
   localparam logic [K_W-1:0]    K_LAST = K_W'(NUM_TAPS / 2 - 1);
   localparam logic [D_W-1:0]    D_ONE  = D_W'(1);
   localparam logic [D_W-1:0]    D_LAST = D_W'(MAC_LAT - 1);

   state_e            state, state_n;
   logic [ADDR_W-1:0] wp, wp_n;
   logic [K_W-1:0]    k, k_n;
   logic [D_W-1:0]    drain, drain_n;
   logic              strb_p;

   logic              wr_en_n, mac_clr_n, mac_en_n, out_valid_n, busy_n, overrun_n;
   logic [ADDR_W-1:0] wr_addr_n, rd_a_n, rd_b_n;
   logic [K_W-1:0]    coef_n;

   sample_strobe_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .sample_strb_i(sample_strb_i),
      .strb_p_o     (strb_p)
   );

   always_comb begin
      state_n = state;
      wp_n    = wp;
      k_n     = k;
      drain_n = drain;
      case (state)
         IDLE:  if (strb_p && enable_i) state_n = WRITE;
         WRITE: begin
            state_n = MAC;
            wp_n    = wp + A_ONE;
            k_n     = '0;
         end
         MAC: begin
            if (k == K_LAST) begin
               state_n = DRAIN;
               drain_n = '0;
            end else begin
               k_n = k + K_ONE;
            end
         end
         DRAIN: begin
            if (drain == D_LAST) state_n = DONE;
            else                 drain_n = drain + D_ONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from the next state/pointer so the registered copies line up with state.
   always_comb begin
      wr_en_n     = (state_n == WRITE);
      mac_clr_n   = wr_en_n;
      wr_addr_n   = wr_en_n ? (wp + A_ONE) : '0;
      mac_en_n    = (state_n == MAC);
      rd_a_n      = mac_en_n ? (wp_n - ADDR_W'(k_n)) : '0;
      rd_b_n      = mac_en_n ? (wp_n + A_ONE + ADDR_W'(k_n)) : '0;
      coef_n      = mac_en_n ? k_n : '0;
      out_valid_n = (state_n == DONE);
      busy_n      = (state_n != IDLE);
      overrun_n   = overrun_o;
      if (strb_p && (state != IDLE)) overrun_n = 1'b1;
      else if (clr_overrun_i)        overrun_n = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         wp          <= '0;
         k           <= '0;
         drain       <= '0;
         wr_en_o     <= 1'b0;
         wr_addr_o   <= '0;
         rd_a_addr_o <= '0;
         rd_b_addr_o <= '0;
         coef_addr_o <= '0;
         mac_clr_o   <= 1'b0;
         mac_en_o    <= 1'b0;
         out_valid_o <= 1'b0;
         busy_o      <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         state       <= state_n;
         wp          <= wp_n;
         k           <= k_n;
         drain       <= drain_n;
         wr_en_o     <= wr_en_n;
         wr_addr_o   <= wr_addr_n;
         rd_a_addr_o <= rd_a_n;
         rd_b_addr_o <= rd_b_n;
         coef_addr_o <= coef_n;
         mac_clr_o   <= mac_clr_n;
         mac_en_o    <= mac_en_n;
         out_valid_o <= out_valid_n;
         busy_o      <= busy_n;
         overrun_o   <= overrun_n;
      end
   end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb/tb_fir_sample_sequencer.sv - scoreboard bench for fir_sample_sequencer with NUM_TAPS=8
module tb_fir_sample_sequencer;

   localparam int N  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n, strb, en, clr;
   logic          wr_en, mac_clr, mac_en, out_valid, busy, overrun;
   logic [AW-1:0] wr_addr, rd_a, rd_b;
   logic [AW-2:0] coef;

   fir_sample_sequencer #(
      .NUM_TAPS(N), .ADDR_W(AW), .MAC_LAT(2), .SYNC_STAGES(2)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .sample_strb_i(strb), .enable_i(en),
      .clr_overrun_i(clr), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
      .rd_a_addr_o(rd_a), .rd_b_addr_o(rd_b), .coef_addr_o(coef),
      .mac_clr_o(mac_clr), .mac_en_o(mac_en), .out_valid_o(out_valid),
      .busy_o(busy), .overrun_o(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   int wp_m = 0;

   typedef struct {
      int cyc;
      int a;
      int b;
      int k;
   } ev_t;

   ev_t wr_q[$];
   ev_t mac_q[$];
   ev_t ov_q[$];

   task automatic chk(input string name, input integer act, input integer exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Strobe rises at cycle c: strb_p at c+3, write at c+4, MAC k at c+5+k, out_valid at c+11.
   task automatic raise(input bit run, input int nmac, input bit valid);
      ev_t e;
      int  c;
      c    = cyc;
      strb = 1'b1;
      if (run) begin
         wp_m  = (wp_m + 1) % N;
         e.cyc = c + 4; e.a = wp_m; e.b = 0; e.k = 0;
         wr_q.push_back(e);
         for (int k = 0; k < nmac; k++) begin
            e.cyc = c + 5 + k;
            e.a   = (wp_m - k + N) % N;
            e.b   = (wp_m + 1 + k) % N;
            e.k   = k;
            mac_q.push_back(e);
         end
         if (valid) begin
            e.cyc = c + 11;
            ov_q.push_back(e);
         end
      end
   endtask

   task automatic sample();
      raise(1'b1, 4, 1'b1);
      tick(4);
      strb = 1'b0;
      tick(16);
   endtask

   task automatic check_zero();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_rd_a", rd_a, 0);
      chk("rst_rd_b", rd_b, 0);
      chk("rst_coef", coef, 0);
      chk("rst_mac_clr", mac_clr, 0);
      chk("rst_mac_en", mac_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      if (rst_n) begin
         if (wr_en) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
               e = wr_q.pop_front();
               chk("wr_cycle", cyc, e.cyc);
               chk("wr_addr", wr_addr, e.a);
               chk("mac_clr", mac_clr, 1);
            end
         end
         if (mac_en) begin
            if (mac_q.size() == 0) chk("mac_unexpected", 1, 0);
            else begin
               e = mac_q.pop_front();
               chk("mac_cycle", cyc, e.cyc);
               chk("rd_a_addr", rd_a, e.a);
               chk("rd_b_addr", rd_b, e.b);
               chk("coef_addr", coef, e.k);
            end
         end
         if (out_valid) begin
            if (ov_q.size() == 0) chk("valid_unexpected", 1, 0);
            else begin
               e = ov_q.pop_front();
               chk("valid_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; strb = 1'b0; en = 1'b1; clr = 1'b0;
      tick(3);
      check_zero();
      rst_n = 1'b1;
      tick(2);

      // Nine samples: addresses 1..7,0,1 with delay-line wrap on the eighth.
      repeat (9) sample();

      // Second edge lands during MAC: dropped, overrun set, pointer untouched.
      raise(1'b1, 4, 1'b1); tick(1); strb = 1'b0; tick(2);
      raise(1'b0, 0, 1'b0); tick(1); strb = 1'b0; tick(4);
      chk("overrun_set", overrun, 1);
      tick(12);
      chk("overrun_sticky", overrun, 1);
      clr = 1'b1; tick(1); clr = 1'b0;
      chk("overrun_cleared", overrun, 0);
      sample();

      // Disabled in IDLE: edge ignored entirely.
      en = 1'b0;
      raise(1'b0, 0, 1'b0); tick(4); strb = 1'b0; tick(16);
      chk("disabled_overrun", overrun, 0);
      chk("disabled_busy", busy, 0);

      // Enable dropped during MAC: run still completes.
      en = 1'b1;
      raise(1'b1, 4, 1'b1); tick(4); strb = 1'b0; tick(2);
      en = 1'b0;
      chk("busy_mid_run", busy, 1);
      tick(14);
      en = 1'b1;

      // Reset while MAC k=2 is on the outputs.
      raise(1'b1, 3, 1'b0); tick(4); strb = 1'b0; tick(3);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_zero();
      wp_m = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(20);
      sample();

      // Clear coincident with a dropped edge: set wins.
      raise(1'b1, 4, 1'b1); tick(1); strb = 1'b0; tick(2);
      raise(1'b0, 0, 1'b0); tick(1); strb = 1'b0; tick(2);
      clr = 1'b1; tick(1); clr = 1'b0;
      chk("overrun_set_wins", overrun, 1);
      tick(16);
      clr = 1'b1; tick(1); clr = 1'b0;
      chk("overrun_final_clear", overrun, 0);

      tick(4);
      chk("wr_queue_drained", wr_q.size(), 0);
      chk("mac_queue_drained", mac_q.size(), 0);
      chk("valid_queue_drained", ov_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
